// File: rtl/store_merge_unit.sv
// Store path between register read port and word-organized data memory: word stores
// write directly, byte/halfword stores read-merge-write. Optional macro STORE_ALIGN_CHECK_EN.
module store_merge_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef STORE_ALIGN_CHECK_EN
  localparam logic [2:0] S_ERR   = 3'd5;
`endif
  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

  logic [2:0]  state_r;
  logic [2:0]  next_s;
  logic [2:0]  cnt_r;
  logic [1:0]  size_r;
  logic [1:0]  off_r;
  logic [31:0] data_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        mem_we_r;
  logic        busy_r;
  logic        done_r;
  logic        reject_s;
  logic        sub_word_s;

  // Little-endian merge of the latched store data into the word read from memory.
  function automatic logic [31:0] merge_word(input logic [1:0] sz, input logic [1:0] off,
                                             input logic [31:0] data, input logic [31:0] old);
    logic [31:0] w;
    w = old;
    case (sz)
      2'b01: begin
        if (off[1]) w[31:16] = data[15:0];
        else        w[15:0]  = data[15:0];
      end
      2'b10: begin
        case (off)
          2'b00:   w[7:0]   = data[7:0];
          2'b01:   w[15:8]  = data[7:0];
          2'b10:   w[23:16] = data[7:0];
          2'b11:   w[31:24] = data[7:0];
          default: w = old;
        endcase
      end
      default: w = data;
    endcase
    return w;
  endfunction

  // Request classification and next-state selection.
  always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
    reject_s = ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
               ((size == 2'b01) && addr[0]) || (size == 2'b11);
`else
    reject_s = 1'b0;
`endif
    sub_word_s = (size == 2'b01) || (size == 2'b10);
    next_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (!start)         next_s = S_IDLE;
`ifdef STORE_ALIGN_CHECK_EN
        else if (reject_s)  next_s = S_ERR;
`endif
        else if (sub_word_s) next_s = S_READ;
        else                next_s = S_WRITE;
      end
      S_READ:  next_s = S_WAIT;
      S_WAIT: begin
        if (cnt_r == 3'd0) next_s = S_WRITE;
        else               next_s = S_WAIT;
      end
      S_WRITE: next_s = S_DONE;
      S_DONE:  next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned_r;
  assign misaligned = misaligned_r;
`else
  assign misaligned = 1'b0;
`endif

  // State, request latch and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= 3'd0;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      data_r      <= 32'h0000_0000;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      misaligned_r <= 1'b0;
`endif
    end else begin
      state_r  <= next_s;
      mem_we_r <= (next_s == S_WRITE);
      busy_r   <= (next_s != S_IDLE);
      done_r   <= (next_s == S_DONE);
`ifdef STORE_ALIGN_CHECK_EN
      misaligned_r <= (next_s == S_ERR);
`endif
      if ((state_r == S_IDLE) && start && !reject_s) begin
        size_r      <= size;
        off_r       <= addr[1:0];
        data_r      <= rt_data;
        mem_addr_r  <= {addr[31:2], 2'b00};
        mem_wdata_r <= rt_data;
      end
      if (state_r == S_READ) begin
        cnt_r <= WAIT_INIT;
      end else if (state_r == S_WAIT) begin
        if (cnt_r == 3'd0) mem_wdata_r <= merge_word(size_r, off_r, data_r, mem_rdata);
        else               cnt_r <= cnt_r - 3'd1;
      end
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: two instances (latency 1 and 3) each with a
// behavioural word memory; directed scenarios plus randomized stores against a reference model.
module tb_store_merge_unit;

  localparam int TRACE = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  size;
  logic [31:0] addr, rt_data;
  logic [31:0] rd1, rd3, r3a, r3b;
  logic [31:0] maddr1, wdata1, maddr3, wdata3;
  logic        we1, busy1, done1, mis1, we3, busy3, done3, mis3;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic        pl_en;
  int          pl_sel;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  logic        tr_we [TRACE];
  logic        tr_busy [TRACE];
  logic        tr_done [TRACE];
  logic        tr_mis [TRACE];
  logic [31:0] tr_addr [TRACE];
  logic [31:0] tr_wdata [TRACE];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_merge_unit #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .size(size), .addr(addr), .rt_data(rt_data),
    .mem_rdata(rd1), .mem_addr(maddr1), .mem_wdata(wdata1), .mem_we(we1),
    .busy(busy1), .done(done1), .misaligned(mis1));

  store_merge_unit #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr), .rt_data(rt_data),
    .mem_rdata(rd3), .mem_addr(maddr3), .mem_wdata(wdata3), .mem_we(we3),
    .busy(busy3), .done(done3), .misaligned(mis3));

  // Behavioural memories: fixed-latency reads, writes on mem_we, pattern fill while in reset.
  always @(posedge clk) begin
    rd1 <= mem1[maddr1[11:2]];
    r3a <= mem3[maddr3[11:2]];
    r3b <= r3a;
    rd3 <= r3b;
    if (!reset) begin
      for (int i = 0; i < 1024; i++) begin
        mem1[i] <= 32'(i) * 32'h9E37_79B1;
        mem3[i] <= 32'(i) * 32'h85EB_CA6B;
      end
    end else if (pl_en) begin
      if (pl_sel == 1) mem1[pl_idx] <= pl_val;
      else             mem3[pl_idx] <= pl_val;
    end else begin
      if (we1) mem1[maddr1[11:2]] <= wdata1;
      if (we3) mem3[maddr3[11:2]] <= wdata3;
    end
  end

  function automatic logic would_reject(input logic [1:0] sz, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0] == 1'b1);
`else
    return 1'b0;
`endif
  endfunction

  // Reference merge: replace the selected byte lanes with a mask and shift.
  function automatic logic [31:0] ref_word(input logic [1:0] sz, input logic [31:0] a,
                                           input logic [31:0] d, input logic [31:0] old);
    logic [31:0] mask;
    int sh;
    if (sz == 2'b10) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
    end else if (sz == 2'b01) begin
      sh = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
    end else begin
      return d;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic preload(input int sel, input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = sel; pl_idx = a[11:2]; pl_val = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic sample(input int sel, input int k);
    tr_we[k]    = (sel == 1) ? we1 : we3;
    tr_busy[k]  = (sel == 1) ? busy1 : busy3;
    tr_done[k]  = (sel == 1) ? done1 : done3;
    tr_mis[k]   = (sel == 1) ? mis1 : mis3;
    tr_addr[k]  = (sel == 1) ? maddr1 : maddr3;
    tr_wdata[k] = (sel == 1) ? wdata1 : wdata3;
  endtask

  // Issue one store (cycle 0) and record outputs for cycles 1..TRACE-1; inputs are scrambled after acceptance.
  task automatic run_store(input int sel, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    size = sz; addr = a; rt_data = d;
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start3 = 1'b0;
    size = 2'($urandom); addr = $urandom; rt_data = $urandom;
    for (int k = 1; k < TRACE; k++) begin
      @(negedge clk);
      sample(sel, k);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({maddr1, wdata1, we1, busy1, done1, mis1} !== 68'd0 ||
        {maddr3, wdata3, we3, busy3, done3, mis3} !== 68'd0) begin
      fails++;
      $display("FAIL reset_state got d1=%h/%h/%b%b%b%b d3=%h/%h/%b%b%b%b required all 0",
               maddr1, wdata1, we1, busy1, done1, mis1, maddr3, wdata3, we3, busy3, done3, mis3);
    end
  endtask

  task automatic test_word_store;
    run_store(1, 2'b00, 32'h0000_0104, 32'hDEAD_BEEF);
    tests++;
    if (tr_we[1] !== 1'b1 || tr_addr[1] !== 32'h104 || tr_wdata[1] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL word_write got we=%b addr=%h data=%h required 1/00000104/deadbeef",
               tr_we[1], tr_addr[1], tr_wdata[1]);
    end
    tests++;
    if (tr_done[2] !== 1'b1 || tr_we[2] !== 1'b0 || tr_busy[1] !== 1'b1 || tr_busy[3] !== 1'b0 || tr_done[3] !== 1'b0) begin
      fails++;
      $display("FAIL word_done got done2=%b we2=%b busy1=%b busy3=%b done3=%b required 1/0/1/0/0",
               tr_done[2], tr_we[2], tr_busy[1], tr_busy[3], tr_done[3]);
    end
  endtask

  task automatic test_byte_store;
    preload(1, 32'h200, 32'h1122_3344);
    run_store(1, 2'b10, 32'h0000_0202, 32'hFFFF_FFAB);
    tests++;
    if (tr_we[1] !== 1'b0 || tr_addr[1] !== 32'h200 || tr_busy[1] !== 1'b1) begin
      fails++;
      $display("FAIL byte_read got we=%b addr=%h busy=%b required 0/00000200/1", tr_we[1], tr_addr[1], tr_busy[1]);
    end
    tests++;
    if (tr_we[3] !== 1'b1 || tr_wdata[3] !== 32'h11AB_3344 || tr_addr[3] !== 32'h200 || tr_we[2] !== 1'b0) begin
      fails++;
      $display("FAIL byte_write got we3=%b data=%h addr=%h we2=%b required 1/11ab3344/00000200/0",
               tr_we[3], tr_wdata[3], tr_addr[3], tr_we[2]);
    end
    tests++;
    if (tr_done[4] !== 1'b1 || tr_done[3] !== 1'b0 || tr_busy[2] !== 1'b1 || tr_busy[3] !== 1'b1) begin
      fails++;
      $display("FAIL byte_done got done4=%b done3=%b busy2=%b busy3=%b required 1/0/1/1",
               tr_done[4], tr_done[3], tr_busy[2], tr_busy[3]);
    end
  endtask

  task automatic test_half_latency;
    preload(3, 32'h200, 32'h1122_3344);
    run_store(3, 2'b01, 32'h0000_0202, 32'h0000_CAFE);
    tests++;
    if (tr_we[5] !== 1'b1 || tr_wdata[5] !== 32'hCAFE_3344 || tr_we[4] !== 1'b0 || tr_done[6] !== 1'b1) begin
      fails++;
      $display("FAIL half_lat3 got we5=%b data=%h we4=%b done6=%b required 1/cafe3344/0/1",
               tr_we[5], tr_wdata[5], tr_we[4], tr_done[6]);
    end
  endtask

  task automatic test_misaligned;
    int nwe, ndone, nmis;
    run_store(1, 2'b00, 32'h0000_0103, 32'h1234_5678);
    nwe = 0; ndone = 0; nmis = 0;
    for (int k = 1; k < TRACE; k++) begin
      nwe += int'(tr_we[k]); ndone += int'(tr_done[k]); nmis += int'(tr_mis[k]);
    end
    tests++;
`ifdef STORE_ALIGN_CHECK_EN
    if (tr_mis[1] !== 1'b1 || nmis != 1 || nwe != 0 || ndone != 0 || tr_busy[2] !== 1'b0) begin
      fails++;
      $display("FAIL misaligned got mis1=%b nmis=%0d nwe=%0d ndone=%0d busy2=%b required 1/1/0/0/0",
               tr_mis[1], nmis, nwe, ndone, tr_busy[2]);
    end
`else
    if (tr_we[1] !== 1'b1 || tr_addr[1] !== 32'h100 || tr_wdata[1] !== 32'h1234_5678 ||
        tr_done[2] !== 1'b1 || nmis != 0) begin
      fails++;
      $display("FAIL unaligned_word got we=%b addr=%h data=%h done2=%b nmis=%0d required 1/00000100/12345678/1/0",
               tr_we[1], tr_addr[1], tr_wdata[1], tr_done[2], nmis);
    end
`endif
  endtask

  task automatic test_reset_mid_store;
    int nwe, ndone;
    @(negedge clk);
    size = 2'b10; addr = 32'h0000_0020; rt_data = 32'h0000_0055; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);              // cycle 1: READ
    @(negedge clk);              // cycle 2: WAIT
    reset = 1'b0;
    @(negedge clk);              // cycle 3
    tests++;
    if ({maddr1, wdata1, we1, busy1, done1, mis1} !== 68'd0) begin
      fails++;
      $display("FAIL reset_mid got addr=%h data=%h we/busy/done/mis=%b%b%b%b required all 0",
               maddr1, wdata1, we1, busy1, done1, mis1);
    end
    reset = 1'b1;
    nwe = 0; ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nwe += int'(we1); ndone += int'(done1);
    end
    tests++;
    if (nwe != 0 || ndone != 0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort got nwe=%0d ndone=%0d busy=%b required 0/0/0", nwe, ndone, busy1);
    end
  endtask

  task automatic test_busy_ignore;
    int nwe, ndone;
    logic [31:0] waddr;
    @(negedge clk);
    size = 2'b00; addr = 32'h0000_0040; rt_data = 32'hAAAA_5555; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    nwe = 0; ndone = 0; waddr = 32'h0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (we1) begin nwe++; waddr = maddr1; end
      ndone += int'(done1);
      if (k == 1) begin addr = 32'h0000_0080; start1 = 1'b1; end
      if (k == 3) start1 = 1'b0;
    end
    tests++;
    if (nwe != 1 || ndone != 1 || waddr !== 32'h40) begin
      fails++;
      $display("FAIL busy_ignore got writes=%0d dones=%0d waddr=%h required 1/1/00000040", nwe, ndone, waddr);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] we_v, done_v, busy_v;
    @(negedge clk);
    size = 2'b00; addr = 32'h0000_0300; rt_data = 32'h0BAD_F00D; start1 = 1'b1;
    we_v = 8'h00; done_v = 8'h00; busy_v = 8'h00;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) start1 = 1'b0;
      @(negedge clk);
      we_v[k] = we1; done_v[k] = done1; busy_v[k] = busy1;
    end
    tests++;
    if (we_v !== 8'b0001_0010 || done_v !== 8'b0010_0100 || busy_v !== 8'b0011_0110) begin
      fails++;
      $display("FAIL back_to_back got we=%b done=%b busy=%b required 00010010/00100100/00110110",
               we_v, done_v, busy_v);
    end
  endtask

  task automatic test_random(input int sel, input int lat, input int n);
    logic [1:0]  sz;
    logic [31:0] a, d, old, exp_data;
    logic        rej, e_we, e_done, e_mis, e_busy;
    int wcyc;
    for (int it = 0; it < n; it++) begin
      sz = 2'($urandom);
      a = {20'h0, 12'($urandom)};
      d = $urandom;
      old = (sel == 1) ? mem1[a[11:2]] : mem3[a[11:2]];
      rej = would_reject(sz, a);
      wcyc = (sz == 2'b01 || sz == 2'b10) ? 2 + lat : 1;
      exp_data = ref_word(sz, a, d, old);
      run_store(sel, sz, a, d);
      for (int k = 1; k < TRACE; k++) begin
        e_we = !rej && (k == wcyc);
        e_done = !rej && (k == wcyc + 1);
        e_mis = rej && (k == 1);
        e_busy = rej ? (k == 1) : (k <= wcyc + 1);
        tests++;
        if (tr_we[k] !== e_we || tr_done[k] !== e_done || tr_mis[k] !== e_mis || tr_busy[k] !== e_busy) begin
          fails++;
          $display("FAIL rand_ctrl L=%0d sz=%b a=%h k=%0d got we/done/mis/busy=%b%b%b%b required %b%b%b%b",
                   lat, sz, a, k, tr_we[k], tr_done[k], tr_mis[k], tr_busy[k], e_we, e_done, e_mis, e_busy);
        end
      end
      if (!rej) begin
        tests++;
        if (tr_wdata[wcyc] !== exp_data || tr_addr[wcyc] !== {a[31:2], 2'b00} ||
            tr_addr[1] !== {a[31:2], 2'b00}) begin
          fails++;
          $display("FAIL rand_data L=%0d sz=%b a=%h d=%h old=%h got data=%h addr=%h/%h required %h/%h",
                   lat, sz, a, d, old, tr_wdata[wcyc], tr_addr[1], tr_addr[wcyc], exp_data, {a[31:2], 2'b00});
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0; pl_en = 1'b0; pl_sel = 1;
    pl_idx = 10'd0; pl_val = 32'h0;
    size = 2'b00; addr = 32'h0; rt_data = 32'h0;
    repeat (3) @(posedge clk);
    test_reset;
    reset = 1'b1;
    test_word_store;
    test_byte_store;
    test_half_latency;
    test_misaligned;
    test_reset_mid_store;
    test_busy_ignore;
    test_back_to_back;
    test_random(1, 1, 25);
    test_random(3, 3, 25);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Memory-side store path of the multicycle CPU: takes a register value and a store size and writes it into word-organized data memory. Word stores go straight to memory; byte and halfword stores use a read-modify-write sequence that merges the new bytes into the existing word. It sits between the register-bank read port and the data memory, driven by the control FSM through a start/done handshake.

## Interface

Parameters:
- MEM_LATENCY, default 1: number of cycles between presenting a read address and `mem_rdata` being valid. Legal range is 1–7.

Ports:
- `clk` input 1: the only clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: request a store. Sampled only in IDLE.
- `size` input 2: store size. 00 = word (sw), 01 = halfword (sh), 10 = byte (sb), 11 = reserved.
- `addr` input 32: byte address of the store.
- `rt_data` input 32: register value. The byte store uses [7:0] and the halfword store uses [15:0].
- `mem_rdata` input 32: read data from memory.
- `mem_addr` output 32: word-aligned memory address; bits [1:0] are always 00.
- `mem_wdata` output 32: write data to memory.
- `mem_we` output 1: memory write enable.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a store completes.
- `misaligned` output 1: one-cycle pulse when a store is rejected.

## Operation

- Memory is little-endian. Byte offset k maps to bits [8k+7:8k].
- When `start`=1 in IDLE, the block latches `size`, `addr` and `rt_data`. The inputs may change afterwards.
- States and transitions:
  - IDLE → WRITE for a word store.
  - IDLE → READ for a byte or halfword store.
  - IDLE → ERR when the alignment check fails.
  - READ → WAIT. READ lasts 1 cycle: `mem_addr` = {addr[31:2],2'b00} and `mem_we`=0.
  - WAIT → WRITE. WAIT lasts MEM_LATENCY cycles; a 3-bit counter is loaded with MEM_LATENCY-1. On the last WAIT cycle, `mem_rdata` is merged with the latched data and the result is registered into `mem_wdata`.
  - WRITE → DONE. WRITE lasts 1 cycle with `mem_we`=1. For a word store, `mem_wdata` = rt_data.
  - DONE → IDLE, with `done`=1 for one cycle.
  - ERR → IDLE, with `misaligned`=1 for one cycle. No memory access occurs.
- Merge rules:
  - Byte store: byte addr[1:0] is replaced by rt_data[7:0]; the other three bytes come from `mem_rdata`.
  - Halfword store: the half at addr[1] is replaced by rt_data[15:0]; the other half comes from `mem_rdata`.
- `mem_addr` holds the same aligned address from READ through WRITE.
- `start` is ignored whenever `busy`=1. No request is queued.
- All outputs are registered. `mem_we` is high only in WRITE.

## Timing

- Reset value of every output is 0: `mem_addr`, `mem_wdata`, `mem_we`, `busy`, `done`, `misaligned`. The state returns to IDLE.
- Reset in any state, including mid-WRITE, takes effect at the next edge. `mem_we` is 0 from that cycle on, and no `done` is issued for the aborted store.
- Cycle 0 is the `start` cycle.
- Word store:
  - WRITE on cycle 1.
  - `done` on cycle 2.
  - IDLE on cycle 3; a new `start` is accepted on cycle 3.
- Byte or halfword store:
  - READ on cycle 1.
  - WAIT on cycles 2 to 1+L, where L = MEM_LATENCY.
  - WRITE on cycle 2+L.
  - `done` on cycle 3+L.
- Misaligned store: `misaligned` on cycle 1, IDLE on cycle 2.
- `done` and `misaligned` are never high in the same cycle.

## Configuration

Macro: `STORE_ALIGN_CHECK_EN`.

- Defined:
  - A word store with addr[1:0]≠00 goes to ERR.
  - A halfword store with addr[0]=1 goes to ERR.
  - size=11 goes to ERR.
- Not defined:
  - ERR is not built and `misaligned` is tied to 0.
  - A word store ignores addr[1:0].
  - A halfword store ignores addr[0].
  - size=11 is treated as a word store.

## Test plan

- **Word store.** addr=0x0000_0104, rt_data=0xDEADBEEF, size=00. Required: cycle 1 has `mem_we`=1, `mem_addr`=0x104, `mem_wdata`=0xDEADBEEF; `done` on cycle 2; no read cycle occurs.
- **Byte store.** Memory word 0x11223344 at 0x200; sb with addr=0x202, rt_data=0xFFFFFFAB, MEM_LATENCY=1. Required: READ at 0x200, then a write of 0x11AB3344; `done` on cycle 4; `busy` high on cycles 1–3.
- **Halfword store with longer latency.** Memory word 0x11223344; sh with addr=0x202, rt_data=0x0000CAFE, MEM_LATENCY=3. Required: write data 0xCAFE3344; WRITE on cycle 5.
- **Misaligned store, macro defined.** sw with addr=0x103. Required: `misaligned`=1 on cycle 1 only; `mem_we` stays 0; no `done`.
- **Misaligned store, macro undefined.** Same stimulus (sw, addr=0x103). Required: write at `mem_addr`=0x100; `done` on cycle 2.
- **Reset and busy handling.** Drive `reset`=0 during the WAIT of a byte store. Required: all outputs 0 and state IDLE on the next cycle, no write. Separately, pulse `start` while `busy`=1. Required: the pulse is ignored, with exactly one `done` per accepted request.
